colour_seq_ctrl: RTL and testbench
==================================

Name: colour_seq_ctrl

Overview:
- Colour-sequence store and checker for the Simon Says datapath.
- Generates pseudo-random colours from an LFSR that free-runs while the player holds the launch keys. Appends one colour per round on the FSM's load_colour strobe.
- Presents the colour selected by the FSM's check_round countdown, both for playback flashing and for checking the player's press.
- Sits beside the game FSM. Consumes its rst_seedgen/start/load_colour/check_round outputs and returns result.

Parameters:
- DEPTH, 32: maximum stored colours; matches 32-round game.
- IDX_W, 6: width of check_round and length.
- SEED, 8'hA5: LFSR load value; must be nonzero.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rst_seedgen  in  1  strobe: reload LFSR with SEED, enter SEEDING.
- start  in  1  strobe: freeze entropy phase, enter RUN.
- load_colour  in  1  strobe: append one colour.
- check_round  in  IDX_W  countdown index from FSM; 0 = none selected.
- player_input  in  4  one-hot button state.
- colour_out  out  4  one-hot expected colour at selected index; 0 if none.
- result  out  1  registered match of player_input vs colour_out.
- length  out  IDX_W  number of stored colours.
- full  out  1  length == DEPTH.
- overflow  out  1  sticky: load_colour seen while full.

Behaviour:
- Reset: state=IDLE, lfsr=SEED, length=0, overflow=0, colour_out=0, result=0, full=0. Memory contents are don't-care; length=0 hides them.
- Reset mid-game is identical to reset from power-up; any strobe in the reset cycle is ignored.
- LFSR: 8-bit Fibonacci, shift left.
  - fb = l[7]^l[5]^l[4]^l[3]; next = {l[6:0], fb}.
  - If the register ever reads 0, load SEED instead.
- States:
  - IDLE: LFSR holds. rst_seedgen -> SEEDING.
  - SEEDING: LFSR advances every cycle. start -> RUN.
  - RUN: LFSR advances only on an accepted load_colour. rst_seedgen -> SEEDING with length cleared to 0 and overflow cleared.
- Priority in one cycle: rst_seedgen > start > load_colour.
- load_colour outside RUN is ignored.
- Append (RUN, load_colour, !full):
  - mem[length] <= lfsr[1:0]; length <= length+1; LFSR advances the same cycle.
  - New entry is visible via colour_out from the next cycle.
- Append when full: no write, length holds, LFSR holds, overflow <= 1 (sticky until reset or rst_seedgen).
- Index mapping:
  - check_round in 1..length selects entry idx = length - check_round. check_round == length is the oldest entry (idx 0); check_round == 1 is the newest.
  - check_round == 0 or check_round > length: colour_out = 0.
- colour_out is combinational from check_round and memory, value = 4'b0001 << mem[idx].
- result: registered every cycle as (colour_out != 0) && (player_input == colour_out).
  - Latency 1 cycle, so it is valid in the FSM's GOOD_TURN.
  - Multi-button presses and no-press both give result = 0.
- full is combinational from length; length never exceeds DEPTH.
- Width rule: length and idx arithmetic are in IDX_W bits; DEPTH must be <= 2**IDX_W - 1.
- Memory: DEPTH x 2-bit register array, synchronous write, asynchronous read.

Optional Feature:
- Macro: COLOUR_SEQ_FIXED_SEED_EN.
- Defined: the LFSR does not advance in SEEDING; rst_seedgen still reloads SEED. Every game produces the same colour sequence, for bench and lab debug.
- Undefined: SEEDING free-runs as specified above, so the sequence depends on how long the player holds the keys.
- RUN behaviour is identical in both builds.

Test Plan:
- FIXED_SEED_EN, SEED=A5: reset, rst_seedgen, start, 3 load_colour strobes -> length=3. check_round=3/2/1 gives colour_out=0010/0100/0010 (LFSR steps A5->4A->95->2A).
- With the above sequence loaded, check_round=2, player_input=0100 -> result=1 one cycle later. player_input=0110 -> result=0. check_round=0 with any input -> colour_out=0, result=0.
- 32 appends then a 33rd load_colour -> full=1 after the 32nd, length stays 32, overflow=1. check_round=32 still returns the first colour.
- load_colour asserted in IDLE and in SEEDING -> length stays 0, LFSR unchanged in IDLE. rst_seedgen+start+load_colour in the same cycle -> state=SEEDING, length=0.
- Without FIXED_SEED_EN, rst_seedgen, wait 10 cycles, start, one load_colour -> stored colour equals lfsr[1:0] after 10 steps from A5, checked against the bench model.
- Reset asserted with length=5 in RUN -> next cycle length=0, state=IDLE, overflow=0, result=0.

Source files
------------

// File: rtl/colour_seq_ctrl_if.sv
// Bundle between the game FSM (master) and the colour sequence store (slave).
interface colour_seq_ctrl_if #(
  parameter int IDX_W = 6
);
  logic             rst_seedgen;
  logic             start;
  logic             load_colour;
  logic [IDX_W-1:0] check_round;
  logic [3:0]       player_input;
  logic [3:0]       colour_out;
  logic             result;
  logic [IDX_W-1:0] length;
  logic             full;
  logic             overflow;

  modport master (
    output rst_seedgen, start, load_colour, check_round, player_input,
    input  colour_out, result, length, full, overflow
  );

  modport slave (
    input  rst_seedgen, start, load_colour, check_round, player_input,
    output colour_out, result, length, full, overflow
  );
endinterface

// File: rtl/colour_seq_ctrl.sv
// Simon Says colour store: LFSR-seeded append-only sequence plus player-press checker.
// Define COLOUR_SEQ_FIXED_SEED_EN to freeze the LFSR during SEEDING for repeatable games.
module colour_seq_ctrl #(
  parameter int         DEPTH = 32,
  parameter int         IDX_W = 6,
  parameter logic [7:0] SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  colour_seq_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SEEDING, RUN} state_t;

  state_t           state;
  logic [7:0]       lfsr;
  logic [IDX_W-1:0] len_q;
  logic             ovf_q;
  logic             result_q;
  logic [1:0]       mem [DEPTH];

  logic [7:0]       lfsr_adv;
  logic [7:0]       lfsr_hold;
  logic             full_w;
  logic             append;
  logic [IDX_W-1:0] idx;
  logic             sel_vld;
  logic [3:0]       colour;

  // A zero register would lock the LFSR; both paths recover through SEED.
  assign lfsr_adv  = (lfsr == 8'h00) ? SEED : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign lfsr_hold = (lfsr == 8'h00) ? SEED : lfsr;

  assign full_w  = (len_q == IDX_W'(DEPTH));
  assign append  = (state == RUN) && !bus.rst_seedgen && bus.load_colour && !full_w;

  // Countdown index: check_round == length is the oldest entry.
  assign idx     = len_q - bus.check_round;
  assign sel_vld = (bus.check_round != '0) && (bus.check_round <= len_q);
  assign colour  = sel_vld ? (4'b0001 << mem[idx[AW-1:0]]) : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lfsr     <= SEED;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      result_q <= 1'b0;
    end else begin
      result_q <= (colour != 4'b0000) && (bus.player_input == colour);
      if (bus.rst_seedgen) begin
        state <= SEEDING;
        lfsr  <= SEED;
        len_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        case (state)
          IDLE: lfsr <= lfsr_hold;
          SEEDING: begin
            if (bus.start) state <= RUN;
`ifdef COLOUR_SEQ_FIXED_SEED_EN
            lfsr <= lfsr_hold;
`else
            lfsr <= lfsr_adv;
`endif
          end
          RUN: begin
            if (bus.load_colour) begin
              if (full_w) begin
                ovf_q <= 1'b1;
                lfsr  <= lfsr_hold;
              end else begin
                len_q <= len_q + 1'b1;
                lfsr  <= lfsr_adv;
              end
            end else begin
              lfsr <= lfsr_hold;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Contents need no reset: length == 0 hides them.
  always_ff @(posedge clk) begin
    if (append) mem[len_q[AW-1:0]] <= lfsr[1:0];
  end

  assign bus.colour_out = colour;
  assign bus.result     = result_q;
  assign bus.length     = len_q;
  assign bus.full       = full_w;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_colour_seq_ctrl.sv
// Directed self-checking bench for colour_seq_ctrl with a small behavioural reference model.
module tb_colour_seq_ctrl;
  localparam int         IDX_W = 6;
  localparam int         DEPTH = 32;
  localparam logic [7:0] SEED  = 8'hA5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  colour_seq_ctrl_if #(.IDX_W(IDX_W)) bus ();
  colour_seq_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .SEED(SEED)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_state;
  logic [7:0] m_lfsr;
  int         m_len;
  logic       m_ovf;
  logic       m_res;
  logic [1:0] m_mem [DEPTH];

  // Hand-computed colours for a game with start one cycle after rst_seedgen.
`ifdef COLOUR_SEQ_FIXED_SEED_EN
  localparam logic [3:0] C3 = 4'b0010, C2 = 4'b0100, C1 = 4'b0010;
`else
  localparam logic [3:0] C3 = 4'b0100, C2 = 4'b0010, C1 = 4'b0100;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] lstep(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [3:0] m_colour(input int cr);
    if (cr == 0 || cr > m_len) return 4'b0000;
    return 4'b0001 << m_mem[m_len - cr];
  endfunction

  task automatic tick();
    logic [3:0] c;
    c     = m_colour(int'(bus.check_round));
    m_res = (c != 4'b0000) && (bus.player_input == c);
    if (reset) begin
      m_state = 0; m_lfsr = SEED; m_len = 0; m_ovf = 1'b0; m_res = 1'b0;
    end else if (bus.rst_seedgen) begin
      m_state = 1; m_lfsr = SEED; m_len = 0; m_ovf = 1'b0;
    end else if (m_state == 1) begin
      if (bus.start) m_state = 2;
`ifndef COLOUR_SEQ_FIXED_SEED_EN
      m_lfsr = lstep(m_lfsr);
`endif
    end else if (m_state == 2 && bus.load_colour) begin
      if (m_len == DEPTH) m_ovf = 1'b1;
      else begin
        m_mem[m_len] = m_lfsr[1:0];
        m_len++;
        m_lfsr = lstep(m_lfsr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic rs, input logic st, input logic ld);
    bus.rst_seedgen = rs; bus.start = st; bus.load_colour = ld;
    tick();
    bus.rst_seedgen = 1'b0; bus.start = 1'b0; bus.load_colour = 1'b0;
  endtask

  task automatic set_cr(input int cr, input logic [3:0] pi);
    bus.check_round  = IDX_W'(cr);
    bus.player_input = pi;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.rst_seedgen = 1'b0; bus.start = 1'b0; bus.load_colour = 1'b0;
    bus.check_round = '0;   bus.player_input = 4'b0000;
    tick(); tick();
    reset = 1'b0;
    check("rst_length",   32'(bus.length),     0);
    check("rst_full",     32'(bus.full),       0);
    check("rst_overflow", 32'(bus.overflow),   0);
    check("rst_colour",   32'(bus.colour_out), 0);
    check("rst_result",   32'(bus.result),     0);
    check("rst_lfsr",     32'(dut.lfsr),       32'hA5);

    // load_colour in IDLE is ignored and the LFSR holds
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0, 1'b1);
    check("idle_load_length", 32'(bus.length), 0);
    check("idle_load_lfsr",   32'(dut.lfsr),   32'hA5);

    // All three strobes together: rst_seedgen wins, then load in SEEDING is ignored
    strobe(1'b1, 1'b1, 1'b1);
    check("prio_length", 32'(bus.length), 0);
    strobe(1'b0, 1'b0, 1'b1);
    check("seed_load_length", 32'(bus.length), 0);
    for (int i = 0; i < 8; i++) tick();
    strobe(1'b0, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b1);
    check("seed10_length", 32'(bus.length), 1);
    set_cr(1, 4'b0000);
    check("seed10_colour", 32'(bus.colour_out), 32'(m_colour(1)));

    // Fresh game: start immediately, three colours with hand-computed values
    strobe(1'b1, 1'b0, 1'b0);
    check("reseed_length", 32'(bus.length), 0);
    strobe(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0, 1'b1);
    check("g2_length", 32'(bus.length), 3);
    set_cr(3, 4'b0000); check("g2_cr3", 32'(bus.colour_out), 32'(C3));
    set_cr(2, 4'b0000); check("g2_cr2", 32'(bus.colour_out), 32'(C2));
    set_cr(1, 4'b0000); check("g2_cr1", 32'(bus.colour_out), 32'(C1));
    set_cr(4, 4'b0000); check("g2_cr_gt_len", 32'(bus.colour_out), 0);
    for (int cr = 1; cr <= 3; cr++) begin
      set_cr(cr, 4'b0000);
      check("g2_model_colour", 32'(bus.colour_out), 32'(m_colour(cr)));
    end

    // Player press checking, one cycle latency
    set_cr(2, C2); tick();
    check("res_match", 32'(bus.result), 1);
    set_cr(2, C2 | 4'b1000); tick();
    check("res_multi", 32'(bus.result), 0);
    set_cr(2, 4'b0000); tick();
    check("res_nopress", 32'(bus.result), 0);
    set_cr(0, 4'b0000);
    check("cr0_colour", 32'(bus.colour_out), 0);
    tick();
    check("cr0_result", 32'(bus.result), 0);
    set_cr(0, 4'b0100); tick();
    check("cr0_press_result", 32'(bus.result), 0);

    // Fill to DEPTH, then one more load overflows
    for (int i = 3; i < DEPTH; i++) begin
      check("fill_not_full", 32'(bus.full), 0);
      strobe(1'b0, 1'b0, 1'b1);
    end
    check("fill_length", 32'(bus.length), DEPTH);
    check("fill_full",   32'(bus.full),   1);
    check("fill_ovf0",   32'(bus.overflow), 0);
    check("fill_lfsr_model", 32'(dut.lfsr), 32'(m_lfsr));
    strobe(1'b0, 1'b0, 1'b1);
    check("ovf_length", 32'(bus.length),   DEPTH);
    check("ovf_flag",   32'(bus.overflow), 1);
    check("ovf_lfsr",   32'(dut.lfsr),     32'(m_lfsr));
    tick();
    check("ovf_sticky", 32'(bus.overflow), 1);
    set_cr(32, 4'b0000); check("full_oldest", 32'(bus.colour_out), 32'(C3));
    set_cr(1, 4'b0000);  check("full_newest", 32'(bus.colour_out), 32'(m_colour(1)));
    set_cr(33, 4'b0000); check("full_cr33",   32'(bus.colour_out), 0);

    // rst_seedgen in RUN clears length and overflow, even with load asserted
    strobe(1'b1, 1'b0, 1'b1);
    check("rs_run_length", 32'(bus.length),   0);
    check("rs_run_ovf",    32'(bus.overflow), 0);
    check("rs_run_full",   32'(bus.full),     0);

    // Mid-game reset with five colours and a pending match
    strobe(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b0, 1'b0, 1'b1);
    check("mid_length", 32'(bus.length), 5);
    set_cr(1, m_colour(1)); tick();
    check("mid_result", 32'(bus.result), 1);
    check("mid_model_result", 32'(bus.result), 32'(m_res));
    reset = 1'b1;
    bus.load_colour = 1'b1;
    tick();
    reset = 1'b0;
    bus.load_colour = 1'b0;
    check("mrst_length", 32'(bus.length),   0);
    check("mrst_ovf",    32'(bus.overflow), 0);
    check("mrst_result", 32'(bus.result),   0);
    check("mrst_colour", 32'(bus.colour_out), 0);
    check("mrst_lfsr",   32'(dut.lfsr),     32'hA5);
    // Back in IDLE: load is ignored
    strobe(1'b0, 1'b0, 1'b1);
    check("mrst_idle_load", 32'(bus.length), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
